// File: rtl/proc_ctrl_fsm.sv
// Control unit for the simple processor: captures IR from DIN, sequences T0..T3, drives decoder codes/enables and bus/ALU strobes.
// Latency: mv/mvi/reserved retire 1 cycle after capture, add/sub 3 cycles after capture; all outputs combinational from Tstep/IR.
// Backpressure: none; Run is sampled only in T0 and ignored elsewhere.
module proc_ctrl_fsm #(
    parameter int DW = 9
) (
    input  logic          Clock,
    input  logic          Resetn,
    input  logic          Run,
    input  logic [DW-1:0] DIN,
    output logic [8:0]    IRq,
    output logic [2:0]    RinW,
    output logic          RinEn,
    output logic [2:0]    RoutW,
    output logic          RoutEn,
    output logic          DINout,
    output logic          Ain,
    output logic          Gin,
    output logic          Gout,
    output logic          AddSub,
    output logic          Done
);

    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } tstep_e;

    localparam logic [2:0] OP_MV  = 3'b000;
    localparam logic [2:0] OP_MVI = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;

    tstep_e     tstep_q, tstep_d;
    logic [8:0] ir_q, ir_d;

    logic [2:0] op_i, fld_x, fld_y;

    assign op_i  = ir_q[8:6];
    assign fld_x = ir_q[5:3];
    assign fld_y = ir_q[2:0];
    assign IRq   = ir_q;

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            tstep_q <= T0;
            ir_q    <= 9'd0;
        end else begin
            tstep_q <= tstep_d;
            ir_q    <= ir_d;
        end
    end

    always_comb begin
        tstep_d = tstep_q;
        ir_d    = ir_q;
        RinW    = 3'd0;
        RinEn   = 1'b0;
        RoutW   = 3'd0;
        RoutEn  = 1'b0;
        DINout  = 1'b0;
        Ain     = 1'b0;
        Gin     = 1'b0;
        Gout    = 1'b0;
        AddSub  = 1'b0;
        Done    = 1'b0;

        case (tstep_q)
            T0: begin
                if (Run) begin
                    ir_d    = DIN[8:0];
                    tstep_d = T1;
                end
            end
            T1: begin
                case (op_i)
                    OP_MV: begin
                        RoutW   = fld_y;
                        RoutEn  = 1'b1;
                        RinW    = fld_x;
                        RinEn   = 1'b1;
                        Done    = 1'b1;
                        tstep_d = T0;
                    end
                    OP_MVI: begin
                        DINout  = 1'b1;
                        RinW    = fld_x;
                        RinEn   = 1'b1;
                        Done    = 1'b1;
                        tstep_d = T0;
                    end
                    OP_ADD, OP_SUB: begin
                        RoutW   = fld_x;
                        RoutEn  = 1'b1;
                        Ain     = 1'b1;
                        tstep_d = T2;
                    end
                    default: begin
                        // reserved opcodes retire as a NOP
                        Done    = 1'b1;
                        tstep_d = T0;
                    end
                endcase
            end
            T2: begin
                RoutW   = fld_y;
                RoutEn  = 1'b1;
                Gin     = 1'b1;
                AddSub  = op_i[0];
                tstep_d = T3;
            end
            T3: begin
                Gout    = 1'b1;
                RinW    = fld_x;
                RinEn   = 1'b1;
                Done    = 1'b1;
                tstep_d = T0;
            end
            default: tstep_d = T0;
        endcase
    end

endmodule

// File: tb/tb_proc_ctrl_fsm.sv
// Randomized bench for proc_ctrl_fsm against a per-phase reference model of instruction behaviour.
module tb_proc_ctrl_fsm;

    logic       Clock;
    logic       Resetn;
    logic       Run;
    logic [8:0] DIN;
    logic [8:0] IRq;
    logic [2:0] RinW, RoutW;
    logic       RinEn, RoutEn, DINout, Ain, Gin, Gout, AddSub, Done;

    int checks = 0;
    int errors = 0;

    logic [13:0] obs;
    assign obs = {RinW, RinEn, RoutW, RoutEn, DINout, Ain, Gin, Gout, AddSub, Done};

    proc_ctrl_fsm #(.DW(9)) dut (
        .Clock  (Clock),
        .Resetn (Resetn),
        .Run    (Run),
        .DIN    (DIN),
        .IRq    (IRq),
        .RinW   (RinW),
        .RinEn  (RinEn),
        .RoutW  (RoutW),
        .RoutEn (RoutEn),
        .DINout (DINout),
        .Ain    (Ain),
        .Gin    (Gin),
        .Gout   (Gout),
        .AddSub (AddSub),
        .Done   (Done)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, required finish before 200000");
        $fatal(1);
    end

    // Number of cycles from capture to retirement
    function automatic int ilen(input logic [8:0] ir);
        return (ir[8:7] == 2'b01) ? 3 : 1;
    endfunction

    // Expected output vector on cycle k (1-based) after the capture edge
    function automatic logic [13:0] model(input logic [8:0] ir, input int k);
        logic [2:0] rinw, routw;
        logic rinen, routen, dinout, ain, gin, gout, addsub, done;
        logic [2:0] x, y;
        x = ir[5:3];
        y = ir[2:0];
        {rinw, rinen, routw, routen, dinout, ain, gin, gout, addsub, done} = '0;
        if (ir[8] == 1'b1) begin
            done = (k == 1);
        end else if (ir[7:6] == 2'b00) begin
            if (k == 1) begin routw = y; routen = 1; rinw = x; rinen = 1; done = 1; end
        end else if (ir[7:6] == 2'b01) begin
            if (k == 1) begin dinout = 1; rinw = x; rinen = 1; done = 1; end
        end else begin
            if (k == 1) begin routw = x; routen = 1; ain = 1; end
            if (k == 2) begin routw = y; routen = 1; gin = 1; addsub = ir[6]; end
            if (k == 3) begin gout = 1; rinw = x; rinen = 1; done = 1; end
        end
        return {rinw, rinen, routw, routen, dinout, ain, gin, gout, addsub, done};
    endfunction

    // Drive inputs just after the rising edge, return at the falling edge for sampling
    task automatic step(input logic r, input logic [8:0] d);
        @(posedge Clock);
        #1;
        Run = r;
        DIN = d;
        @(negedge Clock);
    endtask

    task automatic test_reset();
        Resetn = 1'b0;
        Run    = 1'b1;
        DIN    = 9'h1FF;
        #3;
        checks++;
        if (obs !== 14'd0 || IRq !== 9'd0) begin
            errors++;
            $display("FAIL reset_outputs: got obs=%h IRq=%h, required obs=0000 IRq=000", obs, IRq);
        end
        @(negedge Clock);
        @(negedge Clock);
        checks++;
        if (obs !== 14'd0 || IRq !== 9'd0) begin
            errors++;
            $display("FAIL reset_held: got obs=%h IRq=%h, required 0", obs, IRq);
        end
        Run    = 1'b0;
        Resetn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 9'($urandom));
            checks++;
            if (obs !== 14'd0 || IRq !== 9'd0) begin
                errors++;
                $display("FAIL idle_t0: got obs=%h IRq=%h, required 0", obs, IRq);
            end
        end
    endtask

    // Directed single instructions from the test plan, random junk on Run/DIN after capture
    task automatic test_directed();
        logic [8:0] prog [4];
        int dones;
        prog[0] = 9'b000_011_101;
        prog[1] = 9'b001_110_000;
        prog[2] = 9'b011_001_100;
        prog[3] = 9'b101_010_010;
        for (int p = 0; p < 4; p++) begin
            dones = 0;
            step(1'b1, prog[p]);
            checks++;
            if (obs !== 14'd0) begin
                errors++;
                $display("FAIL t0_with_run[%0d]: got obs=%h, required 0000", p, obs);
            end
            for (int k = 1; k <= ilen(prog[p]); k++) begin
                step(1'($urandom), (p == 1) ? 9'h0AB : 9'($urandom));
                dones += int'(Done);
                checks++;
                if (obs !== model(prog[p], k) || IRq !== prog[p]) begin
                    errors++;
                    $display("FAIL directed[%0d] phase %0d: got obs=%h IRq=%h, required obs=%h IRq=%h",
                             p, k, obs, IRq, model(prog[p], k), prog[p]);
                end
            end
            step(1'b0, 9'($urandom));
            checks++;
            if (obs !== 14'd0 || dones != 1) begin
                errors++;
                $display("FAIL directed_retire[%0d]: got obs=%h dones=%0d, required obs=0000 dones=1", p, obs, dones);
            end
        end
    endtask

    // Run held high: add retires in T3, mv captured in the next T0, mv Done two cycles after add Done
    task automatic test_back_to_back();
        logic [8:0] add_i, mv_i;
        int done_cyc [$];
        add_i = 9'b010_000_001;
        mv_i  = 9'b000_111_000;
        step(1'b1, add_i);
        for (int c = 1; c <= 5; c++) begin
            step(1'b1, mv_i);
            if (Done === 1'b1) done_cyc.push_back(c);
            if (c <= 3) begin
                checks++;
                if (obs !== model(add_i, c) || IRq !== add_i) begin
                    errors++;
                    $display("FAIL b2b_add phase %0d: got obs=%h IRq=%h, required obs=%h IRq=%h",
                             c, obs, IRq, model(add_i, c), add_i);
                end
            end else if (c == 5) begin
                checks++;
                if (obs !== model(mv_i, 1) || IRq !== mv_i) begin
                    errors++;
                    $display("FAIL b2b_mv: got obs=%h IRq=%h, required obs=%h IRq=%h",
                             obs, IRq, model(mv_i, 1), mv_i);
                end
            end
        end
        checks++;
        if (done_cyc.size() != 2 || done_cyc[0] != 3 || done_cyc[1] != 5) begin
            errors++;
            $display("FAIL b2b_done_timing: got %0d done pulses, required pulses at cycles 3 and 5", done_cyc.size());
        end
        Run = 1'b0;
        step(1'b0, 9'd0);
    endtask

    task automatic test_random();
        logic [8:0] ir;
        int gap;
        for (int n = 0; n < 60; n++) begin
            ir  = 9'($urandom);
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                step(1'b0, 9'($urandom));
                checks++;
                if (obs !== 14'd0) begin
                    errors++;
                    $display("FAIL rand_idle: got obs=%h, required 0000", obs);
                end
            end
            step(1'b1, ir);
            checks++;
            if (obs !== 14'd0) begin
                errors++;
                $display("FAIL rand_t0: got obs=%h, required 0000", obs);
            end
            for (int k = 1; k <= ilen(ir); k++) begin
                step(1'($urandom), 9'($urandom));
                checks++;
                if (obs !== model(ir, k) || IRq !== ir ||
                    (int'(RoutEn) + int'(DINout) + int'(Gout)) > 1) begin
                    errors++;
                    $display("FAIL rand ir=%h phase %0d: got obs=%h IRq=%h, required obs=%h IRq=%h",
                             ir, k, obs, IRq, model(ir, k), ir);
                end
            end
        end
    endtask

    // Async reset during T2 of an add: outputs clear without a clock edge, no Done afterwards
    task automatic test_reset_mid();
        logic [8:0] ir;
        int dones;
        ir = 9'b010_101_011;
        step(1'b1, ir);
        step(1'b0, 9'd0);
        step(1'b1, 9'd0);
        checks++;
        if (obs !== model(ir, 2)) begin
            errors++;
            $display("FAIL rst_mid_pre: got obs=%h, required %h", obs, model(ir, 2));
        end
        #2;
        Resetn = 1'b0;
        #1;
        checks++;
        if (obs !== 14'd0 || IRq !== 9'd0) begin
            errors++;
            $display("FAIL rst_mid_async: got obs=%h IRq=%h, required 0", obs, IRq);
        end
        @(negedge Clock);
        Resetn = 1'b1;
        Run    = 1'b0;
        dones  = 0;
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 9'($urandom));
            dones += int'(Done);
        end
        checks++;
        if (obs !== 14'd0 || IRq !== 9'd0 || dones != 0) begin
            errors++;
            $display("FAIL rst_mid_after: got obs=%h IRq=%h dones=%0d, required 0", obs, IRq, dones);
        end
    endtask

    initial begin
        Run = 1'b0;
        DIN = 9'd0;
        test_reset();
        test_directed();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
